// File: rtl/jt49_env_pkg.sv
// Shared JT49 definitions for the envelope generator: shape bit indices,
// envelope limits and the packed debug view of the shape state machine.
package jt49_env_pkg;

  // Bit positions inside the 4-bit shape register {CONT, ATT, ALT, HOLD}.
  localparam int SH_CONT = 3;
  localparam int SH_ATT  = 2;
  localparam int SH_ALT  = 1;
  localparam int SH_HOLD = 0;

  // Last step of a 32-step ramp.
  localparam logic [4:0] STEP_LAST = 5'd31;

  // Observable shape-machine state.
  typedef struct packed {
    logic [4:0] step;  // position inside the current ramp
    logic       inv;   // 1 = rising ramp
    logic       stop;  // ramp frozen, steps ignored
    logic       zero;  // output forced to 0
  } env_state_t;

  // Level decode: forced zero, rising ramp, or falling (inverted) ramp.
  function automatic logic [4:0] env_decode(input env_state_t st);
    if (st.zero) return 5'd0;
    return st.inv ? st.step : ~st.step;
  endfunction

endpackage

// File: rtl/jt49_env_if.sv
// Control and level bundle between the PSG register file / amplitude mux
// and the envelope generator.
//
// Handshake: there is no valid/ready pair. cen and restart are single-cycle
// strobes, sampled on the rising clk edge where they are high; period and
// shape are level inputs sampled live. env, env4, step_tick and the debug
// fields are registered (or decoded from registers) and always valid.
interface jt49_env_if #(
  parameter int PERW = 16
);
  import jt49_env_pkg::*;

  logic            cen;
  logic [PERW-1:0] period;
  logic [3:0]      shape;
  logic            restart;
  logic [4:0]      env;
  logic [3:0]      env4;
  logic            step_tick;
  env_state_t      dbg_state;
  logic [PERW-1:0] dbg_pcnt;

  modport master (
    output cen, period, shape, restart,
    input  env, env4, step_tick, dbg_state, dbg_pcnt
  );

  modport slave (
    input  cen, period, shape, restart,
    output env, env4, step_tick, dbg_state, dbg_pcnt
  );

endinterface

// File: rtl/jt49_env_div.sv
// Envelope period divider: counts cen pulses and raises a one-cycle step
// when the count reaches the programmed period (0 behaves as 1).
module jt49_env_div #(
  parameter int PERW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            restart,
  input  logic [PERW-1:0] period,
  output logic            step,
  output logic [PERW-1:0] pcnt
);

  logic [PERW-1:0] pmax;
  logic [PERW:0]   pcnt_inc;
  logic            hit;

  // Compare against the live period, so a new value applies at the next cen;
  // >= lets a period smaller than the running count expire at once.
  always_comb begin
    pmax     = (period == '0) ? {{(PERW-1){1'b0}}, 1'b1} : period;
    pcnt_inc = {1'b0, pcnt} + {{PERW{1'b0}}, 1'b1};
    hit      = (pcnt_inc >= {1'b0, pmax});
    step     = cen & ~restart & hit;
  end

  // Period counter; restart wins over a coincident cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
    end else if (cen) begin
      pcnt <= hit ? '0 : pcnt_inc[PERW-1:0];
    end
  end

endmodule

// File: rtl/jt49_env.sv
// JT49 envelope generator: divides cen256 by the envelope period and walks
// a 5-bit level through the 16 AY/YM envelope shapes.
module jt49_env
  import jt49_env_pkg::*;
#(
  parameter int PERW = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  jt49_env_if.slave  bus
);

  logic       div_step;
  env_state_t st;
  logic       step_tick;

  jt49_env_div #(.PERW(PERW)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (bus.cen),
    .restart (bus.restart),
    .period  (bus.period),
    .step    (div_step),
    .pcnt    (bus.dbg_pcnt)
  );

  // Shape machine. Shape bits are read live at each wrap; only the initial
  // direction (inv) is captured at restart. Reset leaves the output parked
  // at 0 until the CPU writes a shape.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '{step: 5'd0, inv: 1'b0, stop: 1'b1, zero: 1'b1};
      step_tick <= 1'b0;
    end else begin
      step_tick <= div_step;
      if (bus.restart) begin
        st <= '{step: 5'd0, inv: bus.shape[SH_ATT], stop: 1'b0, zero: 1'b0};
      end else if (div_step && !st.stop) begin
        if (st.step != STEP_LAST) begin
          st.step <= st.step + 5'd1;
        end else if (!bus.shape[SH_CONT]) begin
          st.stop <= 1'b1;
          st.zero <= 1'b1;
        end else if (bus.shape[SH_HOLD]) begin
          st.stop <= 1'b1;
          if (bus.shape[SH_ALT]) st.inv <= ~st.inv;
        end else begin
          st.step <= 5'd0;
          if (bus.shape[SH_ALT]) st.inv <= ~st.inv;
        end
      end
    end
  end

  // Output decode straight from the registers.
  always_comb begin
    bus.env       = env_decode(st);
    bus.env4      = bus.env[4:1];
    bus.step_tick = step_tick;
    bus.dbg_state = st;
  end

endmodule

// File: tb/tb_jt49_env.sv
// Directed bench for jt49_env: ramps, holds, triangles, period corner cases,
// restart priority and asynchronous reset.
module tb_jt49_env;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [4:0] exp_q[$];

  jt49_env_if #(.PERW(16)) bus ();

  jt49_env #(.PERW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are sampled on
  // the falling edge after the active rising edge.
  task automatic cen_pulse();
    @(negedge clk) bus.cen = 1'b1;
    @(negedge clk) bus.cen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_restart(input logic [3:0] sh, input logic [15:0] per);
    @(negedge clk);
    bus.shape   = sh;
    bus.period  = per;
    bus.restart = 1'b1;
    @(negedge clk) bus.restart = 1'b0;
  endtask

  // Expected levels for an alternating continuous shape after k cens.
  task automatic push_triangle(input bit att, input int per, input int ncens);
    int p;
    p = (per == 0) ? 1 : per;
    for (int k = 1; k <= ncens; k++) begin
      int n, w;
      bit rising;
      n = k / p;
      w = n % 32;
      rising = att ^ ((n / 32) % 2 == 1);
      exp_q.push_back(rising ? 5'(w) : 5'(31 - w));
    end
  endtask

  // Expected levels for a single ramp (period 1) followed by a hold value.
  task automatic push_oneshot(input bit att, input int hold, input int extra);
    for (int k = 1; k <= 31; k++) exp_q.push_back(att ? 5'(k) : 5'(31 - k));
    for (int k = 0; k < extra; k++) exp_q.push_back(5'(hold));
  endtask

  // Scoreboard: one cen per expected entry.
  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      cen_pulse();
      check(tag, bus.env, exp_q.pop_front());
      idle(2);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.cen     = 1'b0;
    bus.period  = 16'd1;
    bus.shape   = 4'd0;
    bus.restart = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_env", bus.env, 0);
    check("rst_env4", bus.env4, 0);
    check("rst_tick", bus.step_tick, 0);
    check("rst_stop", bus.dbg_state.stop, 1);
    check("rst_pcnt", bus.dbg_pcnt, 0);
    for (int i = 0; i < 4; i++) begin
      cen_pulse();
      check("rst_idle_env", bus.env, 0);
    end

    // 1101: rise to 31 then hold, step_tick keeps running
    do_restart(4'b1101, 16'd1);
    check("att_start", bus.env, 0);
    check("att_pcnt", bus.dbg_pcnt, 0);
    for (int i = 1; i <= 31; i++) begin
      cen_pulse();
      check("ramp_env", bus.env, i);
      check("ramp_env4", bus.env4, i >> 1);
      check("ramp_tick", bus.step_tick, 1);
      idle(1);
      check("tick_width", bus.step_tick, 0);
      idle(1);
    end
    for (int i = 0; i < 100; i++) begin
      cen_pulse();
      check("hold31_env", bus.env, 31);
      if (i % 10 == 0) check("hold31_tick", bus.step_tick, 1);
      idle(2);
    end

    // 1010 period 2: down, up, down again
    do_restart(4'b1010, 16'd2);
    check("tri_start", bus.env, 31);
    push_triangle(1'b0, 2, 130);
    drain("tri_1010");

    // 1110 period 1: up first
    do_restart(4'b1110, 16'd1);
    check("tri_up_start", bus.env, 0);
    push_triangle(1'b1, 1, 40);
    drain("tri_1110");

    // One-shot shapes
    do_restart(4'b0000, 16'd1);
    check("s0000_start", bus.env, 31);
    push_oneshot(1'b0, 0, 8);
    drain("s0000");
    do_restart(4'b0100, 16'd1);
    check("s0100_start", bus.env, 0);
    push_oneshot(1'b1, 0, 8);
    drain("s0100");
    check("s0100_zero", bus.dbg_state.zero, 1);
    do_restart(4'b1011, 16'd1);
    push_oneshot(1'b0, 31, 8);
    drain("s1011");
    do_restart(4'b1111, 16'd1);
    push_oneshot(1'b1, 0, 8);
    drain("s1111");

    // Period 0 behaves as period 1
    do_restart(4'b1101, 16'd0);
    for (int i = 1; i <= 8; i++) begin
      cen_pulse();
      check("per0_env", bus.env, i);
    end

    // Period 3 lowered to 1 at pcnt=2 and at pcnt=1
    do_restart(4'b1101, 16'd3);
    cen_pulse();
    cen_pulse();
    check("per3_pcnt2", bus.dbg_pcnt, 2);
    check("per3_hold", bus.env, 0);
    bus.period = 16'd1;
    cen_pulse();
    check("per_chg2_env", bus.env, 1);
    do_restart(4'b1101, 16'd3);
    cen_pulse();
    check("per3_pcnt1", bus.dbg_pcnt, 1);
    bus.period = 16'd1;
    cen_pulse();
    check("per_chg1_env", bus.env, 1);

    // Period 5 lowered to 2 while pcnt=3 expires on next cen
    do_restart(4'b1101, 16'd5);
    repeat (3) cen_pulse();
    check("per5_pcnt3", bus.dbg_pcnt, 3);
    check("per5_env", bus.env, 0);
    bus.period = 16'd2;
    cen_pulse();
    check("per_below_env", bus.env, 1);
    check("per_below_pcnt", bus.dbg_pcnt, 0);

    // Restart coincident with a step-producing cen at step=17
    do_restart(4'b1101, 16'd1);
    repeat (17) cen_pulse();
    check("pre_coinc_env", bus.env, 17);
    check("pre_coinc_step", bus.dbg_state.step, 17);
    @(negedge clk);
    bus.cen     = 1'b1;
    bus.restart = 1'b1;
    bus.shape   = 4'b1001;
    @(negedge clk);
    bus.cen     = 1'b0;
    bus.restart = 1'b0;
    check("coinc_env", bus.env, 31);
    check("coinc_step", bus.dbg_state.step, 0);
    check("coinc_pcnt", bus.dbg_pcnt, 0);
    check("coinc_tick", bus.step_tick, 0);
    cen_pulse();
    check("coinc_next", bus.env, 30);

    // Restart without cen clears a partial period
    do_restart(4'b1101, 16'd2);
    cen_pulse();
    check("part_pcnt", bus.dbg_pcnt, 1);
    do_restart(4'b1101, 16'd2);
    cen_pulse();
    check("full_per_a", bus.env, 0);
    cen_pulse();
    check("full_per_b", bus.env, 1);

    // Asynchronous reset mid-triangle at env=12
    do_restart(4'b1110, 16'd1);
    repeat (12) cen_pulse();
    check("pre_rst_env", bus.env, 12);
    #2 rst_n = 1'b0;
    #1 check("async_env", bus.env, 0);
    check("async_pcnt", bus.dbg_pcnt, 0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cen_pulse();
      check("post_rst_env", bus.env, 0);
    end
    check("post_rst_stop", bus.dbg_state.stop, 1);
    do_restart(4'b1110, 16'd1);
    check("post_rst_restart", bus.env, 0);
    cen_pulse();
    check("post_rst_step", bus.env, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
